// File: rtl/poly_byte_encode.sv
// poly_byte_encode
//   Captures one 256 x 12-bit polynomial and streams its ByteEncode_12
//   serialization as OUT_W-bit little-endian words on a valid/ready interface.
//   Encoded bit 12k+b is bit b of coefficient k. Word w carries encoded bits
//   [OUT_W*w +: OUT_W].
//
// Optional feature macro: BYTE_ENCODE_MODQ_EN
//   When defined, a one-cycle REDUCE state replaces every coefficient c >= 3329
//   with c-3329 before sending. This adds one cycle of latency.
//   When undefined, coefficients are emitted bit-exact.
//
// Ports
//   clk_i       clock, all logic on posedge
//   rst_i       asynchronous active-high reset
//   run_i       start pulse, poly_i sampled when idle
//   poly_i      polynomial, coeff k = poly_i[12k +: 12]
//   busy_o      transfer in progress (cycle after accepted run_i .. done_o cycle)
//   done_o      pulse on the handshake of the last word
//   data_o      current output word
//   valid_o     data_o valid
//   ready_i     downstream accepts data_o
//   last_o      valid_o on word N_WORDS-1
//   word_idx_o  index of the word on data_o

module poly_byte_encode #(
    parameter int unsigned OUT_W = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              run_i,
    input  logic [3071:0]                     poly_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic [OUT_W-1:0]                  data_o,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic                              last_o,
    output logic [$clog2(3072/OUT_W)-1:0]     word_idx_o
);

    localparam int unsigned POLY_W  = 3072;
    localparam int unsigned N_COEF  = 256;
    localparam int unsigned N_WORDS = POLY_W / OUT_W;
    localparam int unsigned IDX_W   = $clog2(N_WORDS);

`ifdef BYTE_ENCODE_MODQ_EN
    typedef enum logic [1:0] {StIdle, StReduce, StSend} state_e;
`else
    typedef enum logic [0:0] {StIdle, StSend} state_e;
`endif

    state_e             state_q, state_d;
    logic [POLY_W-1:0]  coef_q, coef_d;
    logic [IDX_W-1:0]   word_q, word_d;
    logic               word_last;
    logic               start;
    logic               handshake;

    assign word_last = (word_q == IDX_W'(N_WORDS - 1));
    assign start     = (state_q == StIdle) && run_i;
    assign handshake = (state_q == StSend) && ready_i;

`ifdef BYTE_ENCODE_MODQ_EN
    localparam logic [11:0] Q = 12'd3329;
    logic [POLY_W-1:0] coef_red;

    // Single conditional subtract per coefficient; 3329..4095 lands on 0..766.
    for (genvar k = 0; k < N_COEF; k++) begin : g_reduce
        logic [11:0] c;
        assign c = coef_q[12*k +: 12];
        assign coef_red[12*k +: 12] = (c >= Q) ? (c - Q) : c;
    end
`endif

    // Word view of the coefficient register.
    logic [OUT_W-1:0] words [N_WORDS];
    for (genvar w = 0; w < N_WORDS; w++) begin : g_words
        assign words[w] = coef_q[OUT_W*w +: OUT_W];
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (run_i) begin
`ifdef BYTE_ENCODE_MODQ_EN
                    state_d = StReduce;
`else
                    state_d = StSend;
`endif
                end
            end
`ifdef BYTE_ENCODE_MODQ_EN
            StReduce: state_d = StSend;
`endif
            StSend: begin
                if (ready_i && word_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            coef_q <= '0;
            word_q <= '0;
        end else begin
            coef_q <= coef_d;
            word_q <= word_d;
        end
    end

    always_comb begin
        coef_d = coef_q;
        word_d = word_q;
        if (start) begin
            coef_d = poly_i;
            word_d = '0;
        end
`ifdef BYTE_ENCODE_MODQ_EN
        if (state_q == StReduce) begin
            coef_d = coef_red;
        end
`endif
        // Counter parks on the last index after done; cleared by the next start.
        if (handshake && !word_last) begin
            word_d = word_q + IDX_W'(1);
        end
    end

    // Outputs: valid_o depends on registered state only, never on ready_i.
    always_comb begin
        valid_o    = (state_q == StSend);
        busy_o     = (state_q != StIdle);
        done_o     = handshake && word_last;
        last_o     = (state_q == StSend) && word_last;
        data_o     = words[word_q];
        word_idx_o = word_q;
    end

endmodule

// File: tb/tb_poly_byte_encode.sv
module tb_poly_byte_encode;

    localparam int OUT_W = 64;
    localparam int NW    = 48;
`ifdef BYTE_ENCODE_MODQ_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 0;
    logic          rst;
    logic          run;
    logic [3071:0] poly;
    logic          busy, done, valid, ready, last;
    logic [63:0]   data;
    logic [5:0]    widx;

    int checks = 0;
    int errors = 0;

    logic [63:0] rx [NW];

    typedef struct {
        string       name;
        int          pat;
        int          widx;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [12];

    always #5 clk = ~clk;

    poly_byte_encode #(.OUT_W(OUT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .run_i      (run),
        .poly_i     (poly),
        .busy_o     (busy),
        .done_o     (done),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .last_o     (last),
        .word_idx_o (widx)
    );

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [3071:0] mk(input int pat, input int seed);
        logic [3071:0] p = '0;
        for (int k = 0; k < 256; k++) begin
            logic [11:0] c;
            case (pat)
                0:       c = 12'hABC;
                1:       c = 12'(k);
                2:       c = (k == 0) ? 12'd3328 : (k == 1) ? 12'd3329 :
                             (k == 2) ? 12'd4095 : 12'd0;
                default: c = 12'((k * 37 + seed * 101) % 4096);
            endcase
            p[12*k +: 12] = c;
        end
        return p;
    endfunction

    // Reference ByteEncode_12: two coefficients -> three bytes.
    function automatic logic [63:0] ref_word(input logic [3071:0] p, input int w);
        logic [7:0]  b [384];
        logic [63:0] r;
        for (int k = 0; k < 128; k++) begin
            logic [11:0] c0, c1;
            c0 = p[24*k +: 12];
            c1 = p[24*k+12 +: 12];
`ifdef BYTE_ENCODE_MODQ_EN
            if (c0 >= 12'd3329) c0 = c0 - 12'd3329;
            if (c1 >= 12'd3329) c1 = c1 - 12'd3329;
`endif
            b[3*k]   = c0[7:0];
            b[3*k+1] = {c1[3:0], c0[11:8]};
            b[3*k+2] = c1[11:4];
        end
        for (int i = 0; i < 8; i++) r[8*i +: 8] = b[8*w + i];
        return r;
    endfunction

    // mode 0: ready held high; 1: 5-cycle stalls at words 0, 17, 47;
    // 2: run_i held high with changing poly_i during the transfer.
    // pre: run already accepted on the preceding edge.
    // chain: raise run_i with nxt on the cycle after done.
    task automatic xfer(input logic [3071:0] p, input bit pre, input int mode,
                        input logic [3071:0] alt, input bit chain, input logic [3071:0] nxt);
        int hs = 0, cyc = 0, first = -1, stall = 0, dones = 0;
        logic pv = 0, pr = 0, pl = 0;
        logic [63:0] pd = '0;
        logic [5:0]  pi = '0;
        if (!pre) begin
            @(negedge clk);
            poly = p;
            run  = 1;
        end
        @(posedge clk);
        while (hs < NW && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (mode == 2) begin
                run = 1;
                poly = alt;
                poly[11:0] = 12'(cyc);
            end else begin
                run = 0;
            end
            ready = 1;
            if (mode == 1 && (hs == 0 || hs == 17 || hs == 47) && stall < 5) begin
                ready = 0;
                stall++;
            end
            #1;
            if (pv && !pr) begin
                chk("stall_valid", 64'(valid), 64'(1));
                chk("stall_data", data, pd);
                chk("stall_idx", 64'(widx), 64'(pi));
                chk("stall_last", 64'(last), 64'(pl));
            end
            if (valid) begin
                if (first < 0) first = cyc;
                chk("idx", 64'(widx), 64'(hs));
                chk("data", data, ref_word(p, hs));
                rx[hs] = data;
                chk("last", 64'(last), 64'(hs == NW - 1));
                chk("busy", 64'(busy), 64'(1));
                if (ready) begin
                    chk("done", 64'(done), 64'(hs == NW - 1));
                    dones += int'(done);
                    hs++;
                    stall = 0;
                end
            end else begin
                chk("no_done_idle", 64'(done), 64'(0));
            end
            pv = valid; pr = ready; pd = data; pi = widx; pl = last;
        end
        chk("handshakes", 64'(hs), 64'(NW));
        chk("latency", 64'(first), 64'(LAT));
        chk("done_count", 64'(dones), 64'(1));
        @(negedge clk);
        if (chain) begin
            poly = nxt;
            run  = 1;
        end else begin
            run  = 0;
        end
        #1;
        chk("valid_after", 64'(valid), 64'(0));
        chk("busy_after", 64'(busy), 64'(0));
    endtask

    task automatic apply_table(input int pat);
        foreach (tbl[i]) begin
            if (tbl[i].pat == pat) chk(tbl[i].name, rx[tbl[i].widx], tbl[i].exp);
        end
    endtask

    initial begin
        tbl[0]  = '{"t1_w0",  0, 0,  64'hCABCABCABCABCABC};
        tbl[1]  = '{"t1_w1",  0, 1,  64'hBCABCABCABCABCAB};
        tbl[2]  = '{"t1_w2",  0, 2,  64'hABCABCABCABCABCA};
        tbl[3]  = '{"t1_w45", 0, 45, 64'hCABCABCABCABCABC};
        tbl[4]  = '{"t1_w46", 0, 46, 64'hBCABCABCABCABCAB};
        tbl[5]  = '{"t1_w47", 0, 47, 64'hABCABCABCABCABCA};
        tbl[6]  = '{"t2_w0",  1, 0,  64'h5004003002001000};
        tbl[7]  = '{"t2_w1",  1, 1,  64'h0A00900800700600};
        tbl[8]  = '{"t2_w47", 1, 47, 64'h0FF0FE0FD0FC0FB0};
`ifdef BYTE_ENCODE_MODQ_EN
        tbl[9]  = '{"t6_w0",  2, 0,  64'h00000002FE000D00};
`else
        tbl[9]  = '{"t6_w0",  2, 0,  64'h0000000FFFD01D00};
`endif
        tbl[10] = '{"t6_w1",  2, 1,  64'h0000000000000000};
        tbl[11] = '{"t6_w47", 2, 47, 64'h0000000000000000};

        rst = 1; run = 0; ready = 0; poly = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_last", 64'(last), 64'(0));
        chk("rst_data", data, 64'(0));
        chk("rst_idx", 64'(widx), 64'(0));
        rst = 0;

        // T1 / T2 / T6: straight transfers, then table checks on captured words
        xfer(mk(0, 0), 0, 0, '0, 0, '0);
        apply_table(0);
        xfer(mk(1, 0), 0, 0, '0, 0, '0);
        apply_table(1);
        xfer(mk(2, 0), 0, 0, '0, 0, '0);
        apply_table(2);

        // T3: backpressure
        xfer(mk(3, 7), 0, 1, '0, 0, '0);

        // T4: run_i spam during transfer, then a new run the cycle after done
        xfer(mk(3, 11), 0, 2, mk(3, 12), 1, mk(3, 13));
        xfer(mk(3, 13), 1, 0, '0, 0, '0);

        // T5: reset mid-transfer at word 20
        begin
            bit hit = 0;
            @(negedge clk);
            poly = mk(3, 21);
            run  = 1;
            @(posedge clk);
            for (int c = 0; c < 100 && !hit; c++) begin
                @(negedge clk);
                run   = 0;
                ready = 1;
                #1;
                if (valid && widx == 6'd20) hit = 1;
            end
            chk("t5_reached_w20", 64'(hit), 64'(1));
            #2 rst = 1;
            #1;
            chk("t5_valid", 64'(valid), 64'(0));
            chk("t5_done", 64'(done), 64'(0));
            chk("t5_busy", 64'(busy), 64'(0));
            chk("t5_idx", 64'(widx), 64'(0));
            @(negedge clk);
            rst = 0;
            xfer(mk(3, 22), 0, 0, '0, 0, '0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
